// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings for the MD issue controller: instruction classes, MD unit
// opcodes and FSM states.
package md_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    ClsNone  = 4'd0,
    ClsMult  = 4'd1,
    ClsMultu = 4'd2,
    ClsDiv   = 4'd3,
    ClsDivu  = 4'd4,
    ClsMfhi  = 4'd5,
    ClsMflo  = 4'd6,
    ClsMthi  = 4'd7,
    ClsMtlo  = 4'd8
  } md_cls_e;

  localparam logic [3:0] MDCNONE = 4'd0;
  localparam logic [3:0] MDCM    = 4'd1;
  localparam logic [3:0] MDCMU   = 4'd2;
  localparam logic [3:0] MDCD    = 4'd3;
  localparam logic [3:0] MDCDU   = 4'd4;

  localparam logic [3:0] MDTNONE = 4'd0;
  localparam logic [3:0] MDTHI   = 4'd1;
  localparam logic [3:0] MDTLO   = 4'd2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssued = 2'd1,
    StRun    = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_issue_ctrl_cls_decode.sv
// Combinational decode of an MD instruction class into MD unit controls.
// Classes 9-15 decode exactly like "none".
module md_cls_decode
  import md_issue_ctrl_pkg::*;
(
  input  logic [3:0] i_cls,
  output logic [3:0] o_cop,
  output logic [3:0] o_wop,
  output logic       o_rop,
  output logic       o_is_calc,
  output logic       o_is_md
);

  always_comb begin
    o_cop     = MDCNONE;
    o_wop     = MDTNONE;
    o_rop     = 1'b0;
    o_is_calc = 1'b0;
    o_is_md   = 1'b1;
    case (i_cls)
      ClsMult:  begin o_cop = MDCM;  o_is_calc = 1'b1; end
      ClsMultu: begin o_cop = MDCMU; o_is_calc = 1'b1; end
      ClsDiv:   begin o_cop = MDCD;  o_is_calc = 1'b1; end
      ClsDivu:  begin o_cop = MDCDU; o_is_calc = 1'b1; end
      ClsMfhi:  ;
      ClsMflo:  o_rop = 1'b1;
      ClsMthi:  o_wop = MDTHI;
      ClsMtlo:  o_wop = MDTLO;
      default:  o_is_md = 1'b0;
    endcase
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue/hazard controller in front of the multiply/divide unit.
// Holds the E-stage MD class, drives start/cop/wop/rop and stalls D on MD hazards.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] D_md_cls,
  input  logic       E_flush,
  input  logic       Req,
  input  logic       md_busy,
  output logic       stall_D,
  output logic       md_start,
  output logic [3:0] md_cop,
  output logic [3:0] md_wop,
  output logic       md_rop,
  output logic [3:0] E_md_cls,
  output logic [1:0] state,
  output logic       err
);

  logic [3:0]       r_e_cls;
  md_state_e        r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_err, w_err_d;

  logic [3:0] w_d_cop, w_d_wop, w_e_cop, w_e_wop;
  logic       w_d_rop, w_d_is_calc, w_d_is_md;
  logic       w_e_rop, w_e_is_calc, w_e_is_md;

  md_cls_decode u_d_dec (
    .i_cls     (D_md_cls),
    .o_cop     (w_d_cop),
    .o_wop     (w_d_wop),
    .o_rop     (w_d_rop),
    .o_is_calc (w_d_is_calc),
    .o_is_md   (w_d_is_md)
  );

  md_cls_decode u_e_dec (
    .i_cls     (r_e_cls),
    .o_cop     (w_e_cop),
    .o_wop     (w_e_wop),
    .o_rop     (w_e_rop),
    .o_is_calc (w_e_is_calc),
    .o_is_md   (w_e_is_md)
  );

  // Only the D-side class test and the E-side controls are needed.
  logic w_unused_dec;
  assign w_unused_dec = ^{w_d_cop, w_d_wop, w_d_rop, w_d_is_calc, w_e_is_md};

  assign md_start = w_e_is_calc & ~Req;
  assign md_cop   = w_e_cop;
  assign md_wop   = Req ? MDTNONE : w_e_wop;
  assign md_rop   = w_e_rop;
  // md_busy lags start by one cycle, so start itself must also stall.
  assign stall_D  = w_d_is_md & (md_start | md_busy);
  assign E_md_cls = r_e_cls;
  assign state    = r_state;
  assign err      = r_err;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_err_d   = r_err;
    unique case (r_state)
      StIdle: begin
        if (md_start) begin
          w_state_d = StIssued;
          w_cnt_d   = '0;
        end
      end
      StIssued: begin
        if (md_busy) begin
          w_state_d = StRun;
          w_cnt_d   = CNT_W'(1);
        end else begin
          w_state_d = StIdle;
          w_err_d   = 1'b1;
        end
        if (md_start) w_err_d = 1'b1;
      end
      StRun: begin
        if (md_busy) begin
          if (r_cnt != '1) w_cnt_d = r_cnt + CNT_W'(1);
        end else begin
          w_state_d = StIdle;
        end
        if (md_start) w_err_d = 1'b1;
      end
      default: w_state_d = StIdle;
    endcase
    if (w_state_d == StRun && w_cnt_d >= CNT_W'(TIMEOUT)) w_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_cls <= ClsNone;
      r_state <= StIdle;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      // A stalled D stage leaves a bubble in E.
      if (Req || E_flush || stall_D) r_e_cls <= ClsNone;
      else                           r_e_cls <= w_d_is_md ? D_md_cls : ClsNone;
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_err   <= w_err_d;
    end
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- E-stage issue and hazard controller sitting directly upstream of the multiply/divide unit.
- Holds the D->E pipeline field for the MD instruction class and drives the MD unit's start/cop/wop/rop.
- Raises the D-stage stall while an MD operation is issuing or in flight.
- Tracks each operation with a small FSM and flags a sticky protocol/timeout error for verification.

Parameters:
- TIMEOUT, 16, maximum md_busy-high cycles tolerated before err is set.
- CNT_W, 5, width of the in-flight cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- D_md_cls  in  4  MD class of the D-stage instruction: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 are treated as none.
- E_flush  in  1  bubble request from other hazard/branch logic.
- Req  in  1  interrupt/exception request; the E-stage instruction must not take effect.
- md_busy  in  1  busy from the MD unit.
- stall_D  out  1  D-stage stall caused by an MD hazard.
- md_start  out  1  start to the MD unit.
- md_cop  out  4  calc opcode to the MD unit.
- md_wop  out  4  write opcode to the MD unit.
- md_rop  out  1  read select: 0 HI, 1 LO.
- E_md_cls  out  4  registered E-stage MD class (drives the E result mux).
- state  out  2  FSM state: 0 IDLE, 1 ISSUED, 2 RUN.
- err  out  1  sticky protocol/timeout error.

Behaviour:
- Reset, clock and polarity: reset reset, synchronous, active-high; clock clk.
- Reset values: E_md_cls=0, state=IDLE, counter=0, err=0. All combinational outputs therefore read 0.
- E register, priority order:
  - reset, Req, E_flush or stall_D: load 0. stall_D inserts a bubble because D holds.
  - otherwise: load D_md_cls, with classes 9-15 loaded as 0.
- md_start = E_md_cls in 1..4 and !Req.
- md_cop (combinational from E_md_cls): 1->MDCM, 2->MDCMU, 3->MDCD, 4->MDCDU, else MDCNONE (0).
- md_wop: 7->MDTHI, 8->MDTLO, else 0. Forced to 0 when Req.
- md_rop = (E_md_cls==6); otherwise 0.
- stall_D = (D_md_cls in 1..8) and (md_start or md_busy).
  - Covers the start cycle, since md_busy rises one cycle after start.
  - An mfhi directly after a mult stalls from the start cycle T through T+5.
  - The instruction enters E at T+6, when HI/LO are updated.
- FSM:
  - IDLE: md_start -> ISSUED; counter=0.
  - ISSUED: md_busy -> RUN with counter=1; !md_busy -> IDLE and err=1 (unit failed to accept).
  - RUN: md_busy -> stay, counter+1 saturating at 2^CNT_W-1; !md_busy -> IDLE.
  - In RUN, err=1 when the counter reaches TIMEOUT.
  - md_start seen in ISSUED or RUN sets err=1 (issue while busy; must never occur because stall_D prevents it). State is unchanged.
- Req arriving while in RUN does not cancel the operation. The MD unit finishes, the FSM stays RUN, and stall_D stays asserted for MD-class D instructions.
- Reset mid-operation: FSM returns to IDLE next edge and err clears. The MD unit resets on the same edge.
- Expected busy window for a start at cycle T:
  - mult/multu: md_busy high T+1..T+5.
  - div/divu: md_busy high T+1..T+10.
- Simultaneous E_flush and stall_D: result is a bubble either way.
- err only clears on reset.

Decomposition:
- Shared header package holds:
  - MD class codes 0-8;
  - MDCM/MDCMU/MDCD/MDCDU/MDCNONE cop codes;
  - MDTHI/MDTLO wop codes;
  - FSM state encodings.
- One natural sub-module, md_cls_decode: combinational map from class to cop/wop/rop/is_calc/is_md. Used for both D_md_cls and E_md_cls.

Test Plan:
- MULT in D, then MFHI, with a model MD unit -> start=1 with cop=MDCM at cycle T. stall_D=1 for T..T+5 (6 cycles). MFHI reaches E at T+6 with rop=0. State sequence IDLE,ISSUED,RUN x5,IDLE. err=0.
- DIVU followed by MTLO -> stall_D=1 for 11 cycles. Then wop=MDTLO for one cycle. Max counter 10.
- MULT in E with Req=1 in the same cycle -> start=0, E_md_cls=0 next cycle, state stays IDLE, stall_D=0.
- DIV running, Req pulsed at T+3, MFLO in D -> md_busy completes at T+10. FSM stays RUN until busy drops. stall_D holds throughout.
- Model holds md_busy high for 20 cycles -> err=1 at RUN counter=16 and stays 1. Reset -> err=0, state=IDLE next edge.
- Model never raises busy after start -> state ISSUED for 1 cycle, then IDLE with err=1.
